// File: rtl/kcpsm6_irq_arbiter.sv
// kcpsm6_irq_arbiter
//   Shares the single KCPSM6 interrupt line among up to 8 event sources.
//   The rising edge of each source is latched as pending. Enabled pending
//   sources are granted round-robin. Further interrupts are held off until
//   firmware writes EOI, and a watchdog recovers when an EOI never arrives.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   irq_src           event inputs (level or pulse), edge-detected
//   port_id/out_port  KCPSM6 I/O address and write data
//   write_strobe      OUTPUT strobe
//   k_write_strobe    OUTPUTK strobe
//   interrupt_ack     KCPSM6 interrupt acknowledge
//   interrupt         interrupt request to KCPSM6
//   irq_rdata         registered read data (ID / PEND / MASK)
//   irq_rsel          combinational: port_id selects one of the readable ports
module kcpsm6_irq_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter logic [7:0]  PA_IRQ_ID   = 8'h20,
  parameter logic [7:0]  PA_IRQ_PEND = 8'h21,
  parameter logic [7:0]  PA_IRQ_MASK = 8'h22,
  parameter logic [7:0]  PA_IRQ_EOI  = 8'h23,
  parameter logic [7:0]  MASK_RST    = 8'hFF,
  parameter int unsigned TIMEOUT     = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               k_write_strobe,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [7:0]         irq_rdata,
  output logic               irq_rsel
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  // Mask is held 8 bits wide, with the bits above NUM_SRC forced to zero,
  // so that readback is already zero-extended.
  localparam logic [7:0] VALID = 8'((9'd1 << NUM_SRC) - 9'd1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, pending_q, pending_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         active_q, active_d;
  logic               lost_q, lost_d;
  logic               tmo_q, tmo_d;
  logic               int_q, int_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [7:0]         rdata_q, rdata_d;

  logic               wr, eoi;
  logic [NUM_SRC-1:0] edge_v;
  logic [7:0]         elig;
  logic [7:0]         pend8;
  logic [3:0]         cand;
  logic               found;
  logic [2:0]         pick;
  logic               ack_clr;
  logic               tmo_set;

  always_comb begin
    wr     = write_strobe | k_write_strobe;
    eoi    = wr && (port_id == PA_IRQ_EOI);
    edge_v = irq_src & ~src_q;
    elig   = 8'(pending_q) & mask_q;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_SRC.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!found && elig[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    active_d = active_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    ack_clr  = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          active_d = pick;
          int_d    = 1'b1;
          state_d  = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (interrupt_ack) begin
          int_d    = 1'b0;
          ack_clr  = 1'b1;
          rr_ptr_d = (active_q == 3'(NUM_SRC - 1)) ? '0 : active_q + 3'd1;
          wdog_d   = '0;
          state_d  = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          state_d = S_IDLE;
        end else if (wdog_q == WD_LAST) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Clear the acknowledged bit first, then OR in new edges so a
    // same-cycle edge on that source is not lost.
    pend8 = 8'(pending_q);
    if (ack_clr) pend8[active_q] = 1'b0;
    pending_d = pend8[NUM_SRC-1:0] | edge_v;

    lost_d = lost_q;
    if (eoi) lost_d = 1'b0;
    if (|(edge_v & pending_q)) lost_d = 1'b1;

    tmo_d = tmo_q;
    if (eoi) tmo_d = 1'b0;
    if (tmo_set) tmo_d = 1'b1;

    mask_d = mask_q;
    if (wr && (port_id == PA_IRQ_MASK)) mask_d = out_port & VALID;

    irq_rsel = (port_id == PA_IRQ_ID) || (port_id == PA_IRQ_PEND) ||
               (port_id == PA_IRQ_MASK);

    rdata_d = rdata_q;
    if (port_id == PA_IRQ_ID)
      rdata_d = {(state_q != S_IDLE), lost_q, tmo_q, 2'b00, active_q};
    else if (port_id == PA_IRQ_PEND)
      rdata_d = 8'(pending_q);
    else if (port_id == PA_IRQ_MASK)
      rdata_d = mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST & VALID;
      rr_ptr_q  <= '0;
      active_q  <= '0;
      lost_q    <= 1'b0;
      tmo_q     <= 1'b0;
      int_q     <= 1'b0;
      wdog_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      rr_ptr_q  <= rr_ptr_d;
      active_q  <= active_d;
      lost_q    <= lost_d;
      tmo_q     <= tmo_d;
      int_q     <= int_d;
      wdog_q    <= wdog_d;
      rdata_q   <= rdata_d;
    end
  end

  assign interrupt = int_q;
  assign irq_rdata = rdata_q;

endmodule

// File: tb/tb_kcpsm6_irq_arbiter.sv
// Directed testbench for kcpsm6_irq_arbiter (NUM_SRC=4, TIMEOUT=16).
module tb_kcpsm6_irq_arbiter;

  localparam logic [7:0] A_ID   = 8'h20;
  localparam logic [7:0] A_PEND = 8'h21;
  localparam logic [7:0] A_MASK = 8'h22;
  localparam logic [7:0] A_EOI  = 8'h23;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_src = '0;
  logic [7:0] port_id = '0;
  logic [7:0] out_port = '0;
  logic       write_strobe = 1'b0;
  logic       k_write_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic       interrupt;
  logic [7:0] irq_rdata;
  logic       irq_rsel;

  int checks = 0;
  int failures = 0;
  logic [7:0] d;

  kcpsm6_irq_arbiter #(
    .NUM_SRC (4),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .interrupt_ack  (interrupt_ack),
    .interrupt      (interrupt),
    .irq_rdata      (irq_rdata),
    .irq_rsel       (irq_rsel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v, input logic k);
    port_id  = a;
    out_port = v;
    if (k) k_write_strobe = 1'b1;
    else   write_strobe   = 1'b1;
    tick();
    write_strobe   = 1'b0;
    k_write_strobe = 1'b0;
    port_id        = 8'h00;
    out_port       = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    port_id = a;
    tick();
    v = irq_rdata;
    port_id = 8'h00;
  endtask

  task automatic pulse(input logic [3:0] b);
    irq_src = b;
    tick();
    irq_src = '0;
  endtask

  task automatic do_ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    irq_src = '0;
    interrupt_ack = 1'b0;
    write_strobe = 1'b0;
    k_write_strobe = 1'b0;
    port_id = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_int got=%b exp=0", interrupt); end
    checks++; if (irq_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", irq_rdata); end
    rd(A_ID, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_id got=%h exp=00", d); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_pend got=%h exp=00", d); end
    rd(A_MASK, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL rst_mask got=%h exp=0f", d); end
    port_id = A_MASK; #1;
    checks++; if (irq_rsel !== 1'b1) begin failures++; $display("FAIL rsel_mask got=%b exp=1", irq_rsel); end
    port_id = A_EOI; #1;
    checks++; if (irq_rsel !== 1'b0) begin failures++; $display("FAIL rsel_eoi got=%b exp=0", irq_rsel); end
    port_id = 8'h00;
  endtask

  task automatic test_single();
    pulse(4'b0100);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL single_int got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL single_id got=%h exp=82", d); end
    do_ack();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_ack_int got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL single_pend got=%h exp=00", d); end
    rd(A_ID, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL single_svc_id got=%h exp=82", d); end
    wr(A_EOI, 8'h00, 1'b0);
    rd(A_ID, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL single_eoi_id got=%h exp=02", d); end
    do_ack();
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL stray_ack_int got=%b exp=0", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL stray_ack_id got=%h exp=02", d); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    pulse(4'b1001);
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rr_int0 got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL rr_first got=%h exp=80", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rr_int1 got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h83) begin failures++; $display("FAIL rr_second got=%h exp=83", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
    // one grant of source 0 moves the pointer to 1
    pulse(4'b0001);
    tick();
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
    pulse(4'b1001);
    tick();
    rd(A_ID, d);
    checks++; if (d !== 8'h83) begin failures++; $display("FAIL rr_ptr1_first got=%h exp=83", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rr_int2 got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL rr_ptr1_second got=%h exp=80", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
  endtask

  task automatic test_mask();
    apply_reset();
    wr(A_MASK, 8'h0E, 1'b0);
    pulse(4'b0001);
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL mask_noint got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL mask_pend got=%h exp=01", d); end
    rd(A_MASK, d);
    checks++; if (d !== 8'h0E) begin failures++; $display("FAIL mask_read got=%h exp=0e", d); end
    wr(A_MASK, 8'hFF, 1'b0);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL mask_wr_int got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL mask_open_int got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL mask_id got=%h exp=80", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
  endtask

  task automatic test_lost();
    apply_reset();
    pulse(4'b0010);
    tick();
    pulse(4'b0010);
    rd(A_ID, d);
    checks++; if (d !== 8'hC1) begin failures++; $display("FAIL lost_id got=%h exp=c1", d); end
    do_ack();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL lost_ack_int got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL lost_pend got=%h exp=00", d); end
    wr(A_EOI, 8'h00, 1'b1);
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL lost_single got=%b exp=0", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL lost_clr_id got=%h exp=01", d); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    pulse(4'b0001);
    tick();
    pulse(4'b0100);
    do_ack();
    for (int i = 0; i < 15; i++) tick();
    rd(A_ID, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL wd_last_svc got=%h exp=80", d); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL wd_idle_int got=%b exp=0", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL wd_tmo_id got=%h exp=20", d); end
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL wd_next_int got=%b exp=1", interrupt); end
    rd(A_ID, d);
    checks++; if (d !== 8'hA2) begin failures++; $display("FAIL wd_next_id got=%h exp=a2", d); end
    wr(A_EOI, 8'h00, 1'b0);
    rd(A_ID, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL wd_eoi_assert got=%h exp=82", d); end
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wr(A_MASK, 8'h0B, 1'b0);
    pulse(4'b0001);
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rmid_int got=%b exp=1", interrupt); end
    irq_src = 4'b0100;
    reset = 1'b1;
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b exp=0", interrupt); end
    reset = 1'b0;
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rmid_pend0 got=%h exp=00", d); end
    rd(A_MASK, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL rmid_mask got=%h exp=0f", d); end
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rmid_relatch_int got=%b exp=1", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL rmid_pend got=%h exp=04", d); end
    rd(A_ID, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL rmid_id got=%h exp=82", d); end
    // source still held high: no second event
    do_ack();
    wr(A_EOI, 8'h00, 1'b0);
    tick();
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL held_noint got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL held_pend got=%h exp=00", d); end
    irq_src = '0;
    tick();
    irq_src = 4'b0100;
    tick();
    irq_src = '0;
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL held_rise_int got=%b exp=1", interrupt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_lost();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/kcpsm6_irq_arbiter.md
Name: kcpsm6_irq_arbiter

Overview:
Shares the single KCPSM6 interrupt line between up to 8 event sources, for example the 1 Hz tick, FFT frame-done and button-change events. Each source edge is latched as pending and granted round-robin among enabled sources. The grant is presented on interrupt, and the winning source ID is exposed on a readable port. The block holds off further interrupts until firmware writes end-of-interrupt (EOI), with a watchdog for missing EOIs. It sits beside the Nexys4 I/O interface, which muxes irq_rdata onto in_port when irq_rsel=1.

Parameters:
NUM_SRC, 4, number of sources, 1..8
PA_IRQ_ID, 8'h20, (i) status/ID port
PA_IRQ_PEND, 8'h21, (i) pending-bits port
PA_IRQ_MASK, 8'h22, (i/o) enable mask port
PA_IRQ_EOI, 8'h23, (o) end-of-interrupt port
MASK_RST, 8'hFF, mask value at reset
TIMEOUT, 2000000, SERVICE watchdog in clk cycles

Ports:
clk  in  1  system clock
reset  in  1  reset
irq_src  in  NUM_SRC  event inputs (level or pulse)
port_id  in  8  KCPSM6 port address
out_port  in  8  KCPSM6 write data
write_strobe  in  1  KCPSM6 OUTPUT strobe
k_write_strobe  in  1  KCPSM6 OUTPUTK strobe
interrupt_ack  in  1  KCPSM6 interrupt acknowledge
interrupt  out  1  to KCPSM6
irq_rdata  out  8  registered read data
irq_rsel  out  1  combinational: port_id is ID, PEND or MASK

Behaviour:
Interface: reset reset, synchronous, active-high; clock clk.

Reset values:
- interrupt=0, irq_rdata=0, pending=0, mask=MASK_RST[NUM_SRC-1:0].
- src_q=0, rr_ptr=0, active_id=0, lost=0, tmo=0, state=IDLE, watchdog counter=0.

Edge capture:
- edge[i] = irq_src[i] & ~src_q[i]; src_q <= irq_src every cycle.
- edge[i] sets pending[i] at the same clock edge. Set wins over a same-cycle clear of that bit.
- An edge while pending[i] is already 1 sets sticky lost.
- Masked sources still latch pending but are never granted.

Write decode (wr = write_strobe | k_write_strobe):
- wr with port_id==PA_IRQ_MASK: mask <= out_port[NUM_SRC-1:0].
- wr with port_id==PA_IRQ_EOI: clears lost and tmo in any state; also SERVICE->IDLE.

Read decode (registered, one-cycle latency, every clk):
- ID: {in_service, lost, tmo, 2'b0, active_id[2:0]}. in_service=1 in ASSERT or SERVICE.
- PEND: pending zero-extended. MASK: mask zero-extended. Other addresses: irq_rdata holds.

State machine:
- IDLE: if (pending & mask)!=0, pick the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC. Then active_id<=index, interrupt<=1, go to ASSERT.
- ASSERT: interrupt held at 1 until interrupt_ack. On ack: interrupt<=0, pending[active_id]<=0 (unless a same-cycle edge), rr_ptr<=(active_id+1) mod NUM_SRC, watchdog<=0, go to SERVICE.
- SERVICE: watchdog increments. EOI -> IDLE. When watchdog==TIMEOUT-1 with no EOI: tmo<=1, go to IDLE.

Timing and boundaries:
- Latency: source first sampled high at edge k -> pending at k -> interrupt=1 after edge k+1. Minimum back-to-back spacing is EOI edge -> IDLE -> interrupt after the next edge.
- Masking active_id while in ASSERT does not withdraw interrupt; the ack still completes normally.
- EOI in IDLE or ASSERT: flags cleared, no state change.
- ack outside ASSERT: ignored.
- Source held high: only one pending event until it drops and rises again.
- Source high when reset releases: counts as an edge on the first cycle.
- Reset mid-operation: all state returns to reset values on that edge; interrupt drops immediately.

Test Plan:
1. Single event: NUM_SRC=4, mask=F, pulse irq_src[2] 1 cycle -> interrupt=1 two edges later. Read ID -> 8'h82. ack -> interrupt=0, PEND=0. EOI -> IDLE.
2. Round-robin fairness: pulse src0 and src3 in the same cycle, rr_ptr=0 -> grant 0. After ack+EOI -> grant 3. Then repeat both together with rr_ptr=1 -> grant 3 first.
3. Masking: mask=4'b1110, pulse src0 -> PEND=01, no interrupt. Write mask=F -> interrupt within 2 cycles, ID=0.
4. Lost event: pulse src1 twice before ack -> ID bit6 (lost)=1 and a single grant. EOI clears lost.
5. Watchdog: TIMEOUT=16, ack without EOI -> after 16 SERVICE cycles tmo=1 (ID bit5) and a pending src is granted next. EOI clears tmo.
6. Reset in ASSERT: interrupt=1, assert reset one cycle -> interrupt=0, PEND=0, MASK=MASK_RST. Src held high through reset -> re-latched on release.
